// File: rtl/spi_ms_seq_pkg.sv
// Shared types, SFR map and frame-time helpers for the spi_ms master sequencer.
package spi_ms_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCfgCtrl,
    StCfgExt,
    StCfgBaud,
    StLoad,
    StFrame,
    StGap,
    StRead
  } state_e;

  localparam logic [1:0] W_CTRL = 2'd0;
  localparam logic [1:0] W_EXT  = 2'd1;
  localparam logic [1:0] W_BAUD = 2'd2;
  localparam logic [1:0] W_DATA = 2'd3;
  localparam logic [2:0] R_DATA = 3'd3;

  localparam int unsigned CTRL_SPE  = 6;
  localparam int unsigned CTRL_MSTR = 4;
  localparam int unsigned CTRL_CPOL = 3;
  localparam int unsigned CTRL_CPHA = 2;

  localparam logic [7:0] EXT_VAL = 8'h01;

  localparam int unsigned TimerW = 15;

  function automatic logic [7:0] ctrl_byte(input logic [1:0] mode);
    logic [7:0] b;
    b            = '0;
    b[CTRL_SPE]  = 1'b1;
    b[CTRL_MSTR] = 1'b1;
    b[CTRL_CPOL] = mode[1];
    b[CTRL_CPHA] = mode[0];
    return b;
  endfunction

  function automatic logic [7:0] baud_byte(input logic [5:0] baud);
    return {1'b0, baud[5:3], 1'b0, baud[2:0]};
  endfunction

  // (SPPR+1) * 2^(SPR+1) * 8 + pad; the largest case is 16384 + pad, so 15 bits suffice.
  function automatic logic [TimerW-1:0] frame_cycles(input logic [5:0] baud,
                                                     input int unsigned pad = 3);
    logic [3:0] mult;
    logic [3:0] shamt;
    mult  = {1'b0, baud[5:3]} + 4'd1;
    shamt = {1'b0, baud[2:0]} + 4'd4;
    return (TimerW'(mult) << shamt) + TimerW'(pad);
  endfunction

endpackage

// File: rtl/spi_ms_seq_if.sv
// Command/response bus plus spi_ms SFR and slave-select signals of the sequencer.
interface spi_ms_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [5:0] cmd_baud;
  logic [2:0] cmd_ss;
  logic [7:0] cmd_tx;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data_i;
  logic [7:0] spssn_o;

  // master: the sequencer itself; slave: host plus spi_ms side.
  modport master (
    input  cmd_valid, cmd_mode, cmd_baud, cmd_ss, cmd_tx, sfr_data_i,
    output cmd_ready, rsp_valid, rsp_data, busy, sfraddr_w, sfrwe, spidata_o, sfraddr_r,
           spssn_o
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_baud, cmd_ss, cmd_tx, sfr_data_i,
    input  cmd_ready, rsp_valid, rsp_data, busy, sfraddr_w, sfrwe, spidata_o, sfraddr_r,
           spssn_o
  );

endinterface

// File: rtl/spi_ms_seq_timer.sv
// Loadable down-counter with zero flag; times write holds, the frame and the gap.
module spi_ms_seq_timer
  import spi_ms_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  output logic              zero
);

  localparam logic [TimerW-1:0] One = TimerW'(1);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_ms_seq.sv
// Sequencer driving an spi_ms master: programs config (cached), loads TX, runs one
// selected frame, then returns the received byte.
module spi_ms_seq
  import spi_ms_seq_pkg::*;
#(
  parameter int unsigned WR_HOLD   = 2,
  parameter int unsigned SS_GAP    = 10,
  parameter int unsigned FRAME_PAD = 3
) (
  input logic          clk,
  input logic          rst,
  spi_ms_seq_if.master bus
);

  // Each phase lasts N cycles: the timer is loaded with N-1 on entry and the
  // phase ends in the cycle it reads zero.
  localparam logic [TimerW-1:0] HoldLd = TimerW'(WR_HOLD - 1);
  localparam logic [TimerW-1:0] GapLd  = TimerW'(SS_GAP - 1);

  state_e state_q, state_d;

  logic [1:0] mode_q;
  logic [5:0] baud_q;
  logic [2:0] ss_q;
  logic [7:0] tx_q;
  logic       cache_vld_q;
  logic [1:0] cache_mode_q;
  logic [5:0] cache_baud_q;
  logic [7:0] rsp_data_q;

  logic              accept;
  logic              cfg_needed;
  logic              cache_upd;
  logic              rsp_cap;
  logic              tmr_load;
  logic              tmr_zero;
  logic [TimerW-1:0] tmr_val;

  assign cfg_needed = !cache_vld_q || (bus.cmd_mode != cache_mode_q) ||
                      (bus.cmd_baud != cache_baud_q);

  spi_ms_seq_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cache_upd = 1'b0;
    rsp_cap   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = HoldLd;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          state_d  = cfg_needed ? StCfgCtrl : StLoad;
        end
      end
      StCfgCtrl: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          state_d  = StCfgExt;
        end
      end
      StCfgExt: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          state_d  = StCfgBaud;
        end
      end
      StCfgBaud: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          cache_upd = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = frame_cycles(baud_q, FRAME_PAD) - TimerW'(1);
          state_d  = StFrame;
        end
      end
      StFrame: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GapLd;
          state_d  = StGap;
        end
      end
      StGap: begin
        // RX register has been addressed for the whole gap; latch it so rsp_data is
        // already valid during the rsp_valid cycle.
        if (tmr_zero) begin
          rsp_cap = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.rsp_valid = (state_q == StRead);
    bus.rsp_data  = rsp_data_q;
    bus.sfrwe     = 1'b0;
    bus.sfraddr_w = W_CTRL;
    bus.spidata_o = 8'h00;
    bus.sfraddr_r = 3'd0;
    bus.spssn_o   = 8'hFF;
    unique case (state_q)
      StCfgCtrl: begin
        bus.sfrwe     = 1'b1;
        bus.sfraddr_w = W_CTRL;
        bus.spidata_o = ctrl_byte(mode_q);
      end
      StCfgExt: begin
        bus.sfrwe     = 1'b1;
        bus.sfraddr_w = W_EXT;
        bus.spidata_o = EXT_VAL;
      end
      StCfgBaud: begin
        bus.sfrwe     = 1'b1;
        bus.sfraddr_w = W_BAUD;
        bus.spidata_o = baud_byte(baud_q);
      end
      StLoad: begin
        bus.sfrwe     = 1'b1;
        bus.sfraddr_w = W_DATA;
        bus.spidata_o = tx_q;
      end
      StFrame: begin
        bus.spssn_o = ~(8'b1 << ss_q);
      end
      StGap, StRead: begin
        bus.sfraddr_r = R_DATA;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      baud_q       <= '0;
      ss_q         <= '0;
      tx_q         <= '0;
      cache_vld_q  <= 1'b0;
      cache_mode_q <= '0;
      cache_baud_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= bus.cmd_mode;
        baud_q <= bus.cmd_baud;
        ss_q   <= bus.cmd_ss;
        tx_q   <= bus.cmd_tx;
      end
      if (cache_upd) begin
        cache_vld_q  <= 1'b1;
        cache_mode_q <= mode_q;
        cache_baud_q <= baud_q;
      end
      if (rsp_cap) begin
        rsp_data_q <= bus.sfr_data_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_ms_seq.sv
// Scoreboard bench for spi_ms_seq with a behavioural SFR/slave loopback model.
module tb_spi_ms_seq;

  localparam int unsigned WrHold   = 2;
  localparam int unsigned SsGap    = 10;
  localparam int unsigned FramePad = 3;

  typedef struct packed {
    logic [1:0]  addr;
    logic [7:0]  data;
    int unsigned len;
  } wr_t;

  typedef struct packed {
    logic [7:0]  ss;
    int unsigned len;
  } frm_t;

  logic clk = 1'b0;
  logic rst;

  spi_ms_seq_if bus ();

  spi_ms_seq #(
    .WR_HOLD  (WrHold),
    .SS_GAP   (SsGap),
    .FRAME_PAD(FramePad)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wr_t        exp_wr_q[$];
  wr_t        obs_wr_q[$];
  frm_t       exp_frm_q[$];
  frm_t       obs_frm_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] obs_rsp_q[$];

  int unsigned rsp_cnt = 0;
  int unsigned acc_cnt = 0;
  int unsigned bad_ss  = 0;
  logic [7:0]  rx_reg  = 8'h00;
  logic [7:0]  pend_slave = 8'h00;

  // Bench-side copy of the config cache.
  bit         m_cache_vld  = 1'b0;
  logic [1:0] m_cache_mode = '0;
  logic [5:0] m_cache_baud = '0;

  assign bus.sfr_data_i = (bus.sfraddr_r == 3'd3) ? rx_reg : 8'h00;

  wr_t  cur_wr;
  bit   wr_act = 1'b0;
  frm_t cur_frm;
  bit   frm_act = 1'b0;

  // Monitor: collapses write-enable runs and select-low runs into records.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_act  = 1'b0;
        frm_act = 1'b0;
      end else begin
        if (bus.sfrwe) begin
          if (wr_act && bus.sfraddr_w == cur_wr.addr && bus.spidata_o == cur_wr.data) begin
            cur_wr.len = cur_wr.len + 1;
          end else begin
            if (wr_act) obs_wr_q.push_back(cur_wr);
            cur_wr = '{addr: bus.sfraddr_w, data: bus.spidata_o, len: 1};
            wr_act = 1'b1;
          end
        end else if (wr_act) begin
          obs_wr_q.push_back(cur_wr);
          wr_act = 1'b0;
        end
        if (bus.spssn_o != 8'hFF) begin
          if ($countones(~bus.spssn_o) != 1) bad_ss = bad_ss + 1;
          if (frm_act && bus.spssn_o == cur_frm.ss) begin
            cur_frm.len = cur_frm.len + 1;
          end else begin
            if (frm_act) obs_frm_q.push_back(cur_frm);
            cur_frm = '{ss: bus.spssn_o, len: 1};
            frm_act = 1'b1;
          end
        end else if (frm_act) begin
          obs_frm_q.push_back(cur_frm);
          frm_act = 1'b0;
          rx_reg  = pend_slave;
        end
        if (bus.rsp_valid) begin
          obs_rsp_q.push_back(bus.rsp_data);
          rsp_cnt = rsp_cnt + 1;
        end
        if (bus.cmd_valid && bus.cmd_ready) acc_cnt = acc_cnt + 1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cache_vld = 1'b0;
    obs_wr_q.delete();
    obs_frm_q.delete();
    obs_rsp_q.delete();
  endtask

  task automatic do_txn(input logic [1:0] mode, input logic [5:0] baud, input logic [2:0] ss,
                        input logic [7:0] tx, input bit hold);
    bit          cfg;
    bit          got;
    int unsigned t;
    int unsigned exp_lat;
    int unsigned lat;
    int unsigned ready_bad;
    int unsigned acc0;
    logic [7:0]  slave;
    wr_t         ew;
    wr_t         ow;
    frm_t        ef;
    frm_t        of;
    logic [7:0]  er;

    cfg = !m_cache_vld || mode != m_cache_mode || baud != m_cache_baud;
    t   = (int'(baud[5:3]) + 1) * (2 ** (int'(baud[2:0]) + 1)) * 8 + FramePad;
    if (cfg) begin
      exp_wr_q.push_back('{addr: 2'd0, data: {4'b0101, mode, 2'b00}, len: WrHold});
      exp_wr_q.push_back('{addr: 2'd1, data: 8'h01, len: WrHold});
      exp_wr_q.push_back('{addr: 2'd2, data: {1'b0, baud[5:3], 1'b0, baud[2:0]}, len: WrHold});
    end
    exp_wr_q.push_back('{addr: 2'd3, data: tx, len: WrHold});
    exp_frm_q.push_back('{ss: ~(8'h01 << ss), len: t});
    slave = 8'($urandom);
    exp_rsp_q.push_back(slave);
    pend_slave   = slave;
    m_cache_vld  = 1'b1;
    m_cache_mode = mode;
    m_cache_baud = baud;
    exp_lat = (cfg ? 3 * WrHold : 0) + WrHold + t + SsGap + 1;

    @(posedge clk);
    #1;
    acc0          = acc_cnt;
    bus.cmd_mode  = mode;
    bus.cmd_baud  = baud;
    bus.cmd_ss    = ss;
    bus.cmd_tx    = tx;
    bus.cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout: cmd_ready got 0 want 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end

    ready_bad = 0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20000; i++) begin
      @(negedge clk);
      lat = i;
      if (hold && bus.cmd_ready) ready_bad++;
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid got 0 want 1");
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL latency: got %0d want %0d", lat, exp_lat);
    end
    @(negedge clk);

    er = exp_rsp_q.pop_front();
    checks++;
    if (obs_rsp_q.size() != 1) begin
      failures++;
      $display("FAIL rsp_count: got %0d want 1", obs_rsp_q.size());
    end else if (obs_rsp_q[0] !== er) begin
      failures++;
      $display("FAIL rsp_data: got %02h want %02h", obs_rsp_q[0], er);
    end
    obs_rsp_q.delete();

    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      checks++;
      if (obs_wr_q.size() == 0) begin
        failures++;
        $display("FAIL sfr_write_missing: got none want w%0d=%02h", ew.addr, ew.data);
      end else begin
        ow = obs_wr_q.pop_front();
        if (ow !== ew) begin
          failures++;
          $display("FAIL sfr_write: got w%0d=%02h x%0d want w%0d=%02h x%0d",
                   ow.addr, ow.data, ow.len, ew.addr, ew.data, ew.len);
        end
      end
    end
    checks++;
    if (obs_wr_q.size() != 0) begin
      failures++;
      $display("FAIL sfr_write_extra: got %0d extra want 0", obs_wr_q.size());
    end
    obs_wr_q.delete();

    ef = exp_frm_q.pop_front();
    checks++;
    if (obs_frm_q.size() != 1) begin
      failures++;
      $display("FAIL frame_count: got %0d want 1", obs_frm_q.size());
    end else begin
      of = obs_frm_q.pop_front();
      if (of !== ef) begin
        failures++;
        $display("FAIL frame: got ss=%02h len=%0d want ss=%02h len=%0d",
                 of.ss, of.len, ef.ss, ef.len);
      end
    end
    obs_frm_q.delete();

    checks++;
    if (bad_ss != 0) begin
      failures++;
      $display("FAIL ss_onehot: got %0d bad cycles want 0", bad_ss);
      bad_ss = 0;
    end

    if (hold) begin
      checks++;
      if (ready_bad != 0) begin
        failures++;
        $display("FAIL ready_while_busy: got %0d cycles want 0", ready_bad);
      end
      checks++;
      if (acc_cnt - acc0 != 1) begin
        failures++;
        $display("FAIL accept_count: got %0d want 1", acc_cnt - acc0);
      end
    end
  endtask

  task automatic test_reset();
    logic [38:0] got;
    do_reset();
    @(negedge clk);
    got = {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.busy, bus.sfrwe, bus.sfraddr_w,
           bus.spidata_o, bus.sfraddr_r, bus.spssn_o};
    checks++;
    if (got !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'hFF}) begin
      failures++;
      $display("FAIL reset_state: got %010h want %010h", got,
               {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'hFF});
    end
  endtask

  task automatic test_first_cmd();
    do_txn(2'b00, 6'o00, 3'd0, 8'hA5, 1'b0);
  endtask

  task automatic test_cached();
    do_txn(2'b00, 6'o00, 3'd0, 8'h3C, 1'b0);
  endtask

  task automatic test_max_frame();
    do_txn(2'b11, 6'o77, 3'd7, 8'hC3, 1'b0);
  endtask

  task automatic test_busy_hold();
    do_txn(2'b10, 6'o01, 3'd4, 8'h96, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_txn(2'b10, 6'o01, 3'd1, 8'h11, 1'b0);
    do_txn(2'b10, 6'o01, 3'd2, 8'h22, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    bit          got;
    int unsigned rc0;
    @(posedge clk);
    #1;
    bus.cmd_mode  = 2'b01;
    bus.cmd_baud  = 6'o12;
    bus.cmd_ss    = 3'd5;
    bus.cmd_tx    = 8'h5A;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.spssn_o != 8'hFF) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL midframe_start: spssn_o got FF want select low");
    end
    repeat (3) @(negedge clk);
    rc0 = rsp_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.spssn_o, bus.sfrwe, bus.rsp_valid} !== {8'hFF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midframe_reset: got ss=%02h we=%0b rv=%0b want ss=FF we=0 rv=0",
               bus.spssn_o, bus.sfrwe, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cache_vld = 1'b0;
    repeat (400) @(negedge clk);
    checks++;
    if (rsp_cnt != rc0) begin
      failures++;
      $display("FAIL midframe_no_rsp: got %0d rsp want 0", rsp_cnt - rc0);
    end
    obs_wr_q.delete();
    obs_frm_q.delete();
    obs_rsp_q.delete();
    do_txn(2'b01, 6'o12, 3'd5, 8'h5A, 1'b0);
  endtask

  task automatic test_sweep();
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 8; p++) begin
        for (int s = 0; s < 3; s++) begin
          do_txn(2'(m), {3'(p), 3'(s)}, 3'(p + s), 8'($urandom), 1'b0);
        end
      end
    end
    for (int s = 3; s < 8; s++) begin
      do_txn(2'(s), {3'd0, 3'(s)}, 3'(s), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = '0;
    bus.cmd_baud  = '0;
    bus.cmd_ss    = '0;
    bus.cmd_tx    = '0;
    test_reset();
    test_first_cmd();
    test_cached();
    test_max_frame();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid_frame();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
